// File: rtl/jt900h_muldiv_pkg.sv
// Shared encodings for the TLCS-900H iterative multiply/divide unit.
package jt900h_muldiv_pkg;

   // Operation selector as driven by the control unit
   localparam logic [1:0] MD_MUL  = 2'b00;
   localparam logic [1:0] MD_MULS = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;
   localparam logic [1:0] MD_DIVS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/jt900h_muldiv_sign.sv
// Sign handling for jt900h_muldiv: operand magnitudes and result signs at
// accept time, sign correction and overflow detection at the fix-up step.
module jt900h_muldiv_sign
   import jt900h_muldiv_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic [1:0]     mode,
   input  logic [2*W-1:0] op0,
   input  logic [W-1:0]   op1,
   output logic [2*W-1:0] mag0_c,
   output logic [W-1:0]   mag1_c,
   output logic           qneg_c,
   output logic           rneg_c,
   output logic           dz_c,
   output logic           big_c,
   input  logic [1:0]     fix_mode,
   input  logic [2*W-1:0] fix_acc,
   input  logic           fix_qneg,
   input  logic           fix_rneg,
   input  logic           fix_dz,
   input  logic           fix_big,
   output logic [2*W-1:0] res_c,
   output logic           v_c
);

   localparam int unsigned W2 = 2 * W;
   localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

   logic [W-1:0] mcand;
   logic [W-1:0] qmag;
   logic [W-1:0] rmag;

   // Accept side: magnitudes, result signs, divide-by-zero and |quotient| >= 2^W
   always_comb begin
      mag0_c = op0;
      mag1_c = op1;
      qneg_c = 1'b0;
      rneg_c = 1'b0;
      dz_c   = 1'b0;
      big_c  = 1'b0;
      mcand  = op0[W-1:0];
      if (mode[1]) begin
         if (mode[0] && op0[W2-1]) mag0_c = -op0;
         if (mode[0] && op1[W-1])  mag1_c = -op1;
         qneg_c = mode[0] & (op0[W2-1] ^ op1[W-1]);
         rneg_c = mode[0] & op0[W2-1];
         dz_c   = (op1 == '0);
         big_c  = (mag0_c[W2-1:W] >= mag1_c);
      end else begin
         if (mode[0] && mcand[W-1]) mcand = -op0[W-1:0];
         if (mode[0] && op1[W-1])   mag1_c = -op1;
         mag0_c = {{W{1'b0}}, mcand};
         qneg_c = mode[0] & (op0[W-1] ^ op1[W-1]);
      end
   end

   // Fix-up side: apply result signs and flag quotients that do not fit
   always_comb begin
      qmag  = fix_acc[W-1:0];
      rmag  = fix_acc[W2-1:W];
      res_c = fix_acc;
      v_c   = 1'b0;
      if (fix_mode[1]) begin
         res_c = {fix_rneg ? -rmag : rmag, fix_qneg ? -qmag : qmag};
         v_c   = fix_dz | fix_big;
         if (fix_mode[0]) v_c = v_c | (fix_qneg ? (qmag > HALF) : qmag[W-1]);
      end else if (fix_qneg) begin
         res_c = -fix_acc;
      end
   end

endmodule

// File: rtl/jt900h_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cen edge, with start/busy/done handshake.
module jt900h_muldiv
   import jt900h_muldiv_pkg::*;
#(
   parameter int unsigned W = 16
) (
   input  logic           rst,
   input  logic           clk,
   input  logic           cen,
   input  logic           start,
   input  logic [1:0]     mode,
   input  logic [2*W-1:0] op0,
   input  logic [W-1:0]   op1,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] dout,
   output logic           v
);

   localparam int unsigned W2 = 2 * W;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W2-1:0]  acc_q, acc_d;
   logic [W-1:0]   sh_q, sh_d;
   logic [W-1:0]   dv_q, dv_d;
   logic [W2-1:0]  op0_q, op0_d;
   logic [1:0]     mode_q, mode_d;
   logic           qneg_q, qneg_d, rneg_q, rneg_d;
   logic           dz_q, dz_d, big_q, big_d;
   logic           busy_q, busy_d, done_q, done_d, v_q, v_d;
   logic [W2-1:0]  dout_q, dout_d;

   logic [W2-1:0]  mag0_c, res_c;
   logic [W-1:0]   mag1_c;
   logic           qneg_c, rneg_c, dz_c, big_c, v_c;
   logic [W:0]     mul_sum, div_top;
   logic [W-1:0]   div_diff;
   logic           div_ge;

   jt900h_muldiv_sign #(.W(W)) u_sign (
      .mode     (mode),
      .op0      (op0),
      .op1      (op1),
      .mag0_c   (mag0_c),
      .mag1_c   (mag1_c),
      .qneg_c   (qneg_c),
      .rneg_c   (rneg_c),
      .dz_c     (dz_c),
      .big_c    (big_c),
      .fix_mode (mode_q),
      .fix_acc  (acc_q),
      .fix_qneg (qneg_q),
      .fix_rneg (rneg_q),
      .fix_dz   (dz_q),
      .fix_big  (big_q),
      .res_c    (res_c),
      .v_c      (v_c)
   );

   // One iteration step: partial-product add and trial subtraction
   always_comb begin
      mul_sum  = {1'b0, acc_q[W2-1:W]} + (sh_q[0] ? {1'b0, dv_q} : '0);
      div_top  = acc_q[W2-1:W-1];
      div_ge   = (div_top >= {1'b0, dv_q});
      div_diff = div_top[W-1:0] - dv_q;
   end

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sh_d    = sh_q;
      dv_d    = dv_q;
      op0_d   = op0_q;
      mode_d  = mode_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      big_d   = big_q;
      busy_d  = busy_q;
      done_d  = done_q;
      dout_d  = dout_q;
      v_d     = v_q;
      if (cen) begin
         done_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  op0_d   = op0;
                  mode_d  = mode;
                  qneg_d  = qneg_c;
                  rneg_d  = rneg_c;
                  dz_d    = dz_c;
                  big_d   = big_c;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  acc_d   = mode[1] ? mag0_c : '0;
                  dv_d    = mode[1] ? mag1_c : mag0_c[W-1:0];
                  sh_d    = mode[1] ? '0 : mag1_c;
                  state_d = dz_c ? ST_FIX : ST_CALC;
               end
            end
            ST_CALC: begin
               if (mode_q[1]) begin
                  acc_d = {div_ge ? div_diff : div_top[W-1:0], acc_q[W-2:0], div_ge};
               end else begin
                  acc_d = {mul_sum, acc_q[W-1:1]};
                  sh_d  = sh_q >> 1;
               end
               cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
               dout_d  = v_c ? op0_q : res_c;
               v_d     = v_c;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         sh_q    <= '0;
         dv_q    <= '0;
         op0_q   <= '0;
         mode_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         big_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         dv_q    <= dv_d;
         op0_q   <= op0_d;
         mode_q  <= mode_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         big_q   <= big_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
         v_q     <= v_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;
   assign v    = v_q;

endmodule

// File: tb/tb_jt900h_muldiv.sv
// Directed bench for jt900h_muldiv with W=8 and W=16 instances.
module tb_jt900h_muldiv;
   import jt900h_muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cen = 1'b1;
   bit   cen_tog = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic        start8 = 1'b0, start16 = 1'b0;
   logic [1:0]  mode8 = '0, mode16 = '0;
   logic [15:0] op0_8 = '0;
   logic [7:0]  op1_8 = '0;
   logic [31:0] op0_16 = '0;
   logic [15:0] op1_16 = '0;
   logic        busy8, done8, v8, busy16, done16, v16;
   logic [15:0] dout8;
   logic [31:0] dout16;

   jt900h_muldiv #(.W(8)) u_dut8 (
      .rst(rst), .clk(clk), .cen(cen), .start(start8), .mode(mode8),
      .op0(op0_8), .op1(op1_8), .busy(busy8), .done(done8), .dout(dout8), .v(v8)
   );

   jt900h_muldiv #(.W(16)) u_dut16 (
      .rst(rst), .clk(clk), .cen(cen), .start(start16), .mode(mode16),
      .op0(op0_16), .op1(op1_16), .busy(busy16), .done(done16), .dout(dout16), .v(v16)
   );

   always #5 clk = ~clk;

   // cen is either held high or toggled every clock
   always @(negedge clk) cen = cen_tog ? ~cen : 1'b1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one request, wait for done, check latency, result and handshake
   task automatic do_op(input bit w16, input logic [1:0] m, input logic [31:0] a,
                        input logic [15:0] b, input logic [31:0] ed, input logic ev,
                        input int elat, input string tag);
      int  n, lat, clks;
      bit  seen, busy_ok;
      logic dn, bz;
      @(negedge clk);
      if (w16) begin
         mode16 = m; op0_16 = a; op1_16 = b; start16 = 1'b1;
      end else begin
         mode8 = m; op0_8 = a[15:0]; op1_8 = b[7:0]; start8 = 1'b1;
      end
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (cen !== 1'b1 && n < 8);
      @(negedge clk);
      start8 = 1'b0; start16 = 1'b0;
      op0_8 = 16'hAAAA; op1_8 = 8'h55; op0_16 = 32'hAAAA_AAAA; op1_16 = 16'h5555;
      check({tag, "_busy_acc"}, 64'(w16 ? busy16 : busy8), 64'd1);
      lat = 0; clks = 0; seen = 1'b0; busy_ok = 1'b1;
      while (!seen && clks < 60) begin
         @(posedge clk);
         clks++;
         if (cen) lat++;
         @(negedge clk);
         dn = w16 ? done16 : done8;
         bz = w16 ? busy16 : busy8;
         if (bz !== !dn) busy_ok = 1'b0;
         if (dn === 1'b1) seen = 1'b1;
      end
      check({tag, "_done"}, 64'(seen), 64'd1);
      check({tag, "_lat"}, 64'(lat), 64'(elat));
      check({tag, "_clks"}, 64'(clks), 64'(cen_tog ? 2 * elat : elat));
      check({tag, "_dout"}, 64'(w16 ? dout16 : {16'h0, dout8}), 64'(ed));
      check({tag, "_v"}, 64'(w16 ? v16 : v8), 64'(ev));
      check({tag, "_busy"}, 64'(busy_ok), 64'd1);
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (cen !== 1'b1 && n < 8);
      @(negedge clk);
      check({tag, "_done_clr"}, 64'(w16 ? done16 : done8), 64'd0);
      check({tag, "_hold"}, 64'(w16 ? dout16 : {16'h0, dout8}), 64'(ed));
   endtask

   initial begin
      int ndone;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_done", 64'(done8), 64'd0);
      check("rst_dout", 64'(dout8), 64'd0);
      check("rst_v", 64'(v8), 64'd0);
      check("rst_dout16", 64'(dout16), 64'd0);
      rst = 1'b0;

      do_op(1'b0, MD_MUL,  32'h00FF, 16'h00FF, 32'hFE01, 1'b0, 9, "mul_ff");
      do_op(1'b0, MD_MULS, 32'h00FF, 16'h0002, 32'hFFFE, 1'b0, 9, "muls_m1x2");
      do_op(1'b0, MD_MULS, 32'h0080, 16'h0080, 32'h4000, 1'b0, 9, "muls_min");
      do_op(1'b0, MD_MULS, 32'h0080, 16'h007F, 32'hC080, 1'b0, 9, "muls_mixed");
      do_op(1'b0, MD_DIV,  32'h0107, 16'h0010, 32'h0710, 1'b0, 9, "div_basic");
      do_op(1'b0, MD_DIVS, 32'hFFF9, 16'h0002, 32'hFFFD, 1'b0, 9, "divs_m7");
      do_op(1'b0, MD_DIVS, 32'h0007, 16'h00FE, 32'h01FD, 1'b0, 9, "divs_7_m2");
      do_op(1'b0, MD_DIVS, 32'hFF80, 16'h0001, 32'h0080, 1'b0, 9, "divs_qmin");
      do_op(1'b0, MD_DIVS, 32'h0080, 16'h0001, 32'h0080, 1'b1, 9, "divs_qovf");
      do_op(1'b0, MD_DIV,  32'h1234, 16'h0000, 32'h1234, 1'b1, 1, "div_zero");
      do_op(1'b0, MD_DIV,  32'h1000, 16'h0001, 32'h1000, 1'b1, 9, "div_ovf");

      // Reset in the middle of a multiply
      @(negedge clk);
      mode8 = MD_MUL; op0_8 = 16'h00FF; op1_8 = 8'hFF; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 64'(busy8), 64'd0);
      check("abort_dout", 64'(dout8), 64'd0);
      check("abort_v", 64'(v8), 64'd0);
      check("abort_done", 64'(done8), 64'd0);
      rst = 1'b0;
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done8 === 1'b1) ndone++;
      end
      check("abort_nodone", 64'(ndone), 64'd0);

      // start held high: re-accept only on the edge after each done
      @(negedge clk);
      mode8 = MD_MUL; op0_8 = 16'h0003; op1_8 = 8'h05; start8 = 1'b1;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done8 === 1'b1) ndone++;
         if (k == 9) begin
            check("held_done9", 64'(done8), 64'd1);
            check("held_busy9", 64'(busy8), 64'd0);
            check("held_dout9", 64'(dout8), 64'h000F);
         end
         if (k == 10) check("held_busy10", 64'(busy8), 64'd1);
         if (k == 19) begin
            check("held_done19", 64'(done8), 64'd1);
            start8 = 1'b0;
         end
      end
      check("held_count", 64'(ndone), 64'd2);

      // Half-rate clock enable
      cen_tog = 1'b1;
      do_op(1'b0, MD_MUL,  32'h00FF, 16'h00FF, 32'hFE01, 1'b0, 9, "cen_mul");
      do_op(1'b0, MD_DIVS, 32'hFFF9, 16'h0002, 32'hFFFD, 1'b0, 9, "cen_divs");
      cen_tog = 1'b0;
      repeat (2) @(negedge clk);

      do_op(1'b1, MD_DIVS, 32'h8000_0000, 16'hFFFF, 32'h8000_0000, 1'b1, 17, "w16_divs_ovf");
      do_op(1'b1, MD_MULS, 32'h0000_8000, 16'h8000, 32'h4000_0000, 1'b0, 17, "w16_muls_min");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jt900h_muldiv.md
# jt900h_muldiv

Iterative multiply/divide unit for the TLCS-900H core, covering MUL, MULS, DIV and DIVS. It is the multi-cycle companion to the single-cycle ALU. The control unit latches operands into it with a start/busy/done handshake and receives a double-width result plus the V flag. Operand width is parametrised: byte forms use W=8, word forms use W=16.

## Interface
Parameters:
- W, 16: operand width. Multiplicand, multiplier and divisor are W bits; dividend and result are 2W bits.

Ports (one clock; reset is asynchronous and active-high):
- rst  in  1: asynchronous reset, active-high.
- clk  in  1: clock.
- cen  in  1: clock enable. Every state change is qualified by cen.
- start  in  1: request. Accepted on a cen edge while busy=0.
- mode  in  2: operation. 00 MUL, 01 MULS, 10 DIV, 11 DIVS.
- op0  in  2W: dividend. For MUL/MULS only op0[W-1:0] is used as the multiplicand.
- op1  in  W: multiplier or divisor.
- busy  out  1: high from the accepting edge until the result edge.
- done  out  1: high for exactly one cen cycle, starting at the result edge.
- dout  out  2W: MUL/MULS gives the product. DIV/DIVS gives {remainder, quotient}, remainder in the upper W bits.
- v  out  1: overflow flag. Meaningful when done=1 and holds until the next accept. Always 0 for MUL/MULS.

## Operation
- States: IDLE, CALC, FIX.
- IDLE → CALC on cen & start. On that edge op0, op1 and mode are latched, the operand magnitudes are taken for signed modes, the result signs are recorded and the iteration counter is cleared.
- DIV/DIVS with op1==0: go IDLE → FIX directly. CALC is skipped and v=1.
- CALC: one iteration per cen edge, W iterations in total.
  - Multiply: shift-add, one multiplier bit per iteration, LSB first.
  - Divide: restoring division, one quotient bit per iteration, MSB first.
  - The counter wraps from W-1 to exit CALC → FIX.
- FIX (one cen edge): apply sign correction, check overflow, write dout/v, pulse done, return to IDLE.
- Signed rules:
  - MULS: two's-complement W×W→2W product. -2^(W-1) × -2^(W-1) = +2^(2W-2), no overflow.
  - DIVS: quotient truncates toward zero; remainder takes the sign of the dividend.
- Overflow rules:
  - DIV: divisor zero, or quotient > 2^W−1.
  - DIVS: divisor zero, or quotient outside [−2^(W−1), 2^(W−1)−1].
  - When v=1, dout = the latched op0, unchanged.
- start while busy=1 is ignored: no queueing, latched operands are unaffected.
- start and done may coincide. A start at the FIX edge is not accepted; the next start is accepted on the following cen edge.

## Timing
- Reset values: busy=0, done=0, dout=0, v=0, state IDLE, counter 0.
- rst mid-operation aborts immediately with the same values. No done is produced for the aborted request.
- Latency, counted in cen edges with the accepting edge as edge 0:
  - Normal: result edge is W+1. For W=8 that is edge 9, so done is high after edge 9; the next start is accepted at edge 10 or later.
  - Divide-by-zero: result edge is 1.
- busy rises after the accepting edge and falls after the result edge.
- done is high for one cen cycle. With cen low, done and every other output hold their values.
- dout and v change only at result edges and at reset.

## Structure
- The mode encodings MD_MUL, MD_MULS, MD_DIV and MD_DIVS belong in the shared jt900h.inc, alongside the ALU selector constants.
- Natural sub-module: jt900h_muldiv_sign (combinational). It produces the operand magnitudes and result signs at accept time and the negation/overflow check at FIX.
- The datapath and FSM stay in the top module:
  - a 2W accumulator/remainder register;
  - a W-bit shift register;
  - a counter of $clog2(W) bits.

## Test plan
All values use W=8, except the last line.
- MUL, op0=0x00FF, op1=0xFF → after 9 cen edges: dout=0xFE01, v=0; busy high for edges 1–9 exactly.
- MULS, op0=0x00FF (−1), op1=0x02 → dout=0xFFFE. MULS 0x0080×0x80 → dout=0x4000, v=0.
- DIV, op0=0x0107, op1=0x10 → dout=0x0710, v=0. DIVS op0=0xFFF9 (−7), op1=0x02 → dout=0xFFFD (rem −1, quot −3), v=0.
- DIV, op0=0x1234, op1=0x00 → done after edge 1, v=1, dout=0x1234. DIV op0=0x1000, op1=0x01 → v=1 after edge 9, dout=0x1000.
- Mid-operation events:
  - rst at edge 4 of a MUL → busy=0, dout=0, no done.
  - start held high throughout → a new accept only on the edge after each done.
  - cen toggling 50% → same results, with latency doubled in clk cycles.
- W=16 instance, DIVS op0=0x80000000, op1=0xFFFF → v=1 (quotient +2^31 does not fit). MULS 0x8000×0x8000 → dout=0x40000000.
